// File: rtl/ysyx_25060170_ifu_pipe_pkg.sv
// Shared constants and FSM helper for the pipelined instruction fetch unit.
package ysyx_25060170_ifu_pipe_pkg;

   localparam int unsigned XLEN_DEFAULT     = 32;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

   // Fetch FSM encodings
   localparam logic [1:0] ST_IDLE = 2'd0;   // may issue a request
   localparam logic [1:0] ST_WAIT = 2'd1;   // request accepted, response will be kept
   localparam logic [1:0] ST_DROP = 2'd2;   // request accepted, response will be discarded

   // Next fetch state from the current state and this cycle's handshake events.
   function automatic logic [1:0] fsm_next(
      input logic [1:0] st,
      input logic       accept,
      input logic       rsp,
      input logic       redirect
   );
      logic [1:0] n;
      n = ST_IDLE;
      case (st)
         ST_IDLE: begin
            if (accept) begin
               n = redirect ? ST_DROP : ST_WAIT;
            end else begin
               n = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (rsp) begin
               n = ST_IDLE;
            end else if (redirect) begin
               n = ST_DROP;
            end else begin
               n = ST_WAIT;
            end
         end
         ST_DROP: begin
            if (rsp) begin
               n = ST_IDLE;
            end else begin
               n = ST_DROP;
            end
         end
         default: n = ST_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ysyx_25060170_ifu_fifo.sv
// Circular fetch queue holding {pc, inst} pairs. Flush wins over push/pop.
module ysyx_25060170_ifu_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= {AW{1'b0}};
         r_rd    <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
      end else if (flush) begin
         r_wr    <= {AW{1'b0}};
         r_rd    <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
      end else begin
         if (push) r_wr <= r_wr + AW'(1);
         if (pop)  r_rd <= r_rd + AW'(1);
         case ({push, pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; data only, so no reset is needed
   always_ff @(posedge clk) begin
      if (push && !flush) r_mem[r_wr] <= wdata;
   end

   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == {CW{1'b0}});
   assign count = r_count;
   assign head  = empty ? {WIDTH{1'b0}} : r_mem[r_rd];

endmodule

// File: rtl/ysyx_25060170_ifu_pipe.sv
// Pipelined fetch unit: owns the fetch PC, issues one outstanding imem request,
// queues returned instructions and presents the queue head to ID.
module ysyx_25060170_ifu_pipe
   import ysyx_25060170_ifu_pipe_pkg::*;
#(
   parameter  int              XLEN     = 32,
   parameter  logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_DEFAULT),
   parameter  int              FQ_DEPTH = 4,
   localparam int              CNT_W    = $clog2(FQ_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ie_pc_jump,
   input  logic [XLEN-1:0]  ie_pc_i,
   input  logic             ls_pc_jump,
   input  logic [XLEN-1:0]  ls_pc_i,
   input  logic             id_pc_jump,
   input  logic [XLEN-1:0]  id_pc_i,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [XLEN-1:0]  imem_rsp_inst,
   output logic             if_valid,
   input  logic             id_ready,
   input  logic             id_stall,
   output logic [XLEN-1:0]  pc_o,
   output logic [XLEN-1:0]  inst_o,
   output logic [CNT_W-1:0] fq_count
);

   logic [1:0]        r_state;
   logic [XLEN-1:0]   r_fetch_pc;
   logic [XLEN-1:0]   r_req_pc;     // PC of the request currently outstanding

   logic              w_redirect;
   logic [XLEN-1:0]   w_target;
   logic              w_stall_eff;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [2*XLEN-1:0] w_head;

   assign w_redirect  = ie_pc_jump | ls_pc_jump | id_pc_jump;
   // An EX or LSU redirect squashes whatever ID is stalling on
   assign w_stall_eff = id_stall & ~(ie_pc_jump | ls_pc_jump);

   // Redirect target with fixed priority ie > ls > id
   always_comb begin
      w_target = id_pc_i;
      if (ie_pc_jump) begin
         w_target = ie_pc_i;
      end else if (ls_pc_jump) begin
         w_target = ls_pc_i;
      end else begin
         w_target = id_pc_i;
      end
   end

   // Requests only go out when a queue slot is guaranteed, so a push never meets a full queue
   assign imem_req_valid = (r_state == ST_IDLE) & ~w_full & ~rst;
   assign imem_req_addr  = r_fetch_pc;
   assign w_accept       = imem_req_valid & imem_req_ready;
   assign w_push         = (r_state == ST_WAIT) & imem_rsp_valid & ~w_redirect;

   assign if_valid = ~w_empty & ~w_redirect;
   assign w_pop    = if_valid & id_ready & ~w_stall_eff;

   // Fetch state, fetch PC and the PC tag of the in-flight request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= PC_RESET;
         r_req_pc   <= {XLEN{1'b0}};
      end else begin
         r_state <= fsm_next(r_state, w_accept, imem_rsp_valid, w_redirect);
         if (w_redirect) begin
            r_fetch_pc <= w_target;
         end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
         end
         if (w_accept) r_req_pc <= r_fetch_pc;
      end
   end

   ysyx_25060170_ifu_fifo #(
      .DEPTH (FQ_DEPTH),
      .WIDTH (2 * XLEN)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .flush (w_redirect),
      .wdata ({r_req_pc, imem_rsp_inst}),
      .full  (w_full),
      .empty (w_empty),
      .count (fq_count),
      .head  (w_head)
   );

   assign pc_o   = w_head[2*XLEN-1:XLEN];
   assign inst_o = w_head[XLEN-1:0];

endmodule

// File: tb/tb_ysyx_25060170_ifu_pipe.sv
// Self-checking bench: memory responder, directed scenarios and random stimulus.
// Expected fetch stream = program order from the last reset/redirect target.
module tb_ysyx_25060170_ifu_pipe;

   localparam int          XLEN     = 32;
   localparam int          FQ_DEPTH = 4;
   localparam int          CNT_W    = 3;
   localparam logic [31:0] PC_RST   = 32'h8000_0000;

   logic             clk;
   logic             rst;
   logic             ie_pc_jump, ls_pc_jump, id_pc_jump;
   logic [XLEN-1:0]  ie_pc_i, ls_pc_i, id_pc_i;
   logic             imem_req_valid, imem_req_ready;
   logic [XLEN-1:0]  imem_req_addr;
   logic             imem_rsp_valid;
   logic [XLEN-1:0]  imem_rsp_inst;
   logic             if_valid, id_ready, id_stall;
   logic [XLEN-1:0]  pc_o, inst_o;
   logic [CNT_W-1:0] fq_count;

   ysyx_25060170_ifu_pipe #(.XLEN(XLEN), .PC_RESET(PC_RST), .FQ_DEPTH(FQ_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .ie_pc_jump(ie_pc_jump), .ie_pc_i(ie_pc_i),
      .ls_pc_jump(ls_pc_jump), .ls_pc_i(ls_pc_i),
      .id_pc_jump(id_pc_jump), .id_pc_i(id_pc_i),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_inst(imem_rsp_inst),
      .if_valid(if_valid), .id_ready(id_ready), .id_stall(id_stall),
      .pc_o(pc_o), .inst_o(inst_o), .fq_count(fq_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory content: a fixed scramble of the address
   function automatic logic [31:0] mem_inst(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Reference model: expected program-order PC stream toward ID
   logic [31:0] exp_q[$];
   logic [31:0] model_next;

   task automatic top_up();
      while (exp_q.size() < 8) begin
         exp_q.push_back(model_next);
         model_next = model_next + 32'd4;
      end
   endtask

   task automatic restart_stream(input logic [31:0] t);
      exp_q.delete();
      model_next = t;
      top_up();
   endtask

   // Memory responder: one response per accepted request after 0..lat_max idle cycles
   bit          pend;
   logic [31:0] pend_addr;
   int          pend_dly;
   int          lat_min = 0;
   int          lat_max = 0;
   bit          inj = 1'b0;

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_inst  = 32'd0;
      pend           = 1'b0;
      pend_addr      = 32'd0;
      pend_dly       = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 1'b0;
         end else begin
            if (imem_rsp_valid) pend = 1'b0;
            if (imem_req_valid && imem_req_ready) begin
               pend      = 1'b1;
               pend_addr = imem_req_addr;
               pend_dly  = int'($urandom_range(lat_max, lat_min));
            end
         end
         @(posedge clk);
         #1;
         if (inj) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_inst  = 32'hDEAD_BEEF;
            inj            = 1'b0;
         end else if (pend && pend_dly == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_inst  = mem_inst(pend_addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_inst  = 32'd0;
            if (pend) pend_dly--;
         end
      end
   end

   // Monitor: pops the scoreboard on every dequeue and checks interface invariants
   logic        prev_hold = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   initial begin
      logic        redir, stall_eff;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         redir     = ie_pc_jump | ls_pc_jump | id_pc_jump;
         stall_eff = id_stall & ~(ie_pc_jump | ls_pc_jump);
         if (!rst) begin
            if (redir) check("if_valid_in_redirect", 32'(if_valid), 32'd0);
            if (fq_count == 3'd0) begin
               check("empty_if_valid", 32'(if_valid), 32'd0);
               check("empty_pc_o", pc_o, 32'd0);
               check("empty_inst_o", inst_o, 32'd0);
            end
            check("count_bound", 32'(fq_count <= 3'(FQ_DEPTH)), 32'd1);
            if (fq_count == 3'(FQ_DEPTH)) check("full_no_req", 32'(imem_req_valid), 32'd0);
            if (prev_hold) begin
               check("req_hold_valid", 32'(imem_req_valid), 32'd1);
               check("req_hold_addr", imem_req_addr, prev_addr);
            end
            if (if_valid && id_ready && !stall_eff) begin
               if (exp_q.size() == 0) begin
                  check("pop_underflow", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("pop_pc", pc_o, e);
                  check("pop_inst", inst_o, mem_inst(e));
               end
            end
            prev_hold = imem_req_valid & ~imem_req_ready & ~redir;
            prev_addr = imem_req_addr;
         end else begin
            prev_hold = 1'b0;
         end
      end
   end

   // Stimulus helpers: inputs always change #1 after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      top_up();
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      ie_pc_jump = 1'b0;
      ls_pc_jump = 1'b0;
      id_pc_jump = 1'b0;
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_pc_o", pc_o, 32'd0);
      check("rst_inst_o", inst_o, 32'd0);
      check("rst_count", 32'(fq_count), 32'd0);
      tick();
      tick();
      restart_stream(PC_RST);
      rst = 1'b0;
   endtask

   task automatic jump(input bit j_ie, input bit j_ls, input bit j_id,
                       input logic [31:0] t_ie, input logic [31:0] t_ls, input logic [31:0] t_id);
      logic [31:0] t;
      ie_pc_jump = j_ie; ie_pc_i = t_ie;
      ls_pc_jump = j_ls; ls_pc_i = t_ls;
      id_pc_jump = j_id; id_pc_i = t_id;
      if (j_ie)      t = t_ie;
      else if (j_ls) t = t_ls;
      else           t = t_id;
      restart_stream(t);
      #1;
      check("redirect_if_valid", 32'(if_valid), 32'd0);
      tick();
      ie_pc_jump = 1'b0;
      ls_pc_jump = 1'b0;
      id_pc_jump = 1'b0;
   endtask

   // Wait (bounded) for the next accepted request and check its address
   task automatic wait_accept(input string name, input logic [31:0] exp_addr, output logic [CNT_W-1:0] cnt);
      bit found;
      found = 1'b0;
      cnt   = '0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            found = 1'b1;
            cnt   = fq_count;
            check(name, imem_req_addr, exp_addr);
         end
      end
      if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
      top_up();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CNT_W-1:0] c;
      int highs, doubles;
      logic last_v;
      logic [31:0] t;
      bit b_ie, b_ls, b_id;

      rst = 1'b1;
      ie_pc_jump = 1'b0; ls_pc_jump = 1'b0; id_pc_jump = 1'b0;
      ie_pc_i = 32'd0; ls_pc_i = 32'd0; id_pc_i = 32'd0;
      imem_req_ready = 1'b0; id_ready = 1'b0; id_stall = 1'b0;
      model_next = PC_RST;
      tick();

      // Sequential fetch with zero-latency memory
      do_reset();
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      wait_accept("seq_addr0", 32'h8000_0000, c);
      wait_accept("seq_addr1", 32'h8000_0004, c);
      wait_accept("seq_addr2", 32'h8000_0008, c);
      highs = 0; doubles = 0; last_v = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if_valid) highs++;
         if (if_valid && last_v) doubles++;
         last_v = if_valid;
      end
      tick();
      check("ifv_rate", 32'(highs), 32'd5);
      check("ifv_no_back2back", 32'(doubles), 32'd0);

      // Fill the queue with ID not ready, then release one slot
      do_reset();
      id_ready = 1'b0;
      repeat (14) tick();
      check("fill_count", 32'(fq_count), 32'd4);
      check("fill_req_valid", 32'(imem_req_valid), 32'd0);
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      wait_accept("refill_addr", 32'h8000_0010, c);
      repeat (3) tick();
      check("refill_count", 32'(fq_count), 32'd4);

      // EX redirect while waiting for a slow response
      do_reset();
      id_ready = 1'b1;
      lat_min = 2; lat_max = 2;
      wait_accept("wait_addr", 32'h8000_0000, c);
      jump(1'b1, 1'b0, 1'b0, 32'h8000_1000, 32'h0, 32'h0);
      wait_accept("ie_redir_addr", 32'h8000_1000, c);
      check("ie_redir_count", 32'(c), 32'd0);
      lat_min = 0; lat_max = 0;

      // Priority: ie over id, then ls over id
      imem_req_ready = 1'b0;
      repeat (2) tick();
      jump(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'h0000_0200);
      imem_req_ready = 1'b1;
      wait_accept("prio_ie_id", 32'h0000_0100, c);
      imem_req_ready = 1'b0;
      repeat (2) tick();
      jump(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0300, 32'h0000_0400);
      imem_req_ready = 1'b1;
      wait_accept("prio_ls_id", 32'h0000_0300, c);

      // ID stall holds the head; an LSU redirect overrides it
      do_reset();
      id_ready = 1'b0;
      repeat (14) tick();
      id_ready = 1'b1;
      id_stall = 1'b1;
      repeat (4) tick();
      check("stall_count", 32'(fq_count), 32'd4);
      check("stall_head_pc", pc_o, 32'h8000_0000);
      jump(1'b0, 1'b1, 1'b0, 32'h0, 32'h8000_2000, 32'h0);
      check("ls_flush_count", 32'(fq_count), 32'd0);
      id_stall = 1'b0;
      wait_accept("ls_addr", 32'h8000_2000, c);

      // Reset during WAIT, then a stale response while idle
      lat_min = 3; lat_max = 3;
      do_reset();
      wait_accept("pre_rst_addr", 32'h8000_0000, c);
      rst = 1'b1;
      imem_req_ready = 1'b0;
      tick();
      tick();
      restart_stream(PC_RST);
      rst = 1'b0;
      lat_min = 0; lat_max = 0;
      tick();
      inj = 1'b1;
      repeat (4) tick();
      check("stale_count", 32'(fq_count), 32'd0);
      check("stale_if_valid", 32'(if_valid), 32'd0);
      imem_req_ready = 1'b1;
      wait_accept("post_rst_addr", PC_RST, c);

      // Random traffic against the program-order model
      lat_min = 0; lat_max = 2;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         imem_req_ready = ($urandom % 4) != 0;
         id_ready       = ($urandom % 3) != 0;
         id_stall       = ($urandom % 5) == 0;
         if ($urandom % 16 == 0) begin
            b_ie = $urandom % 2; b_ls = $urandom % 2; b_id = $urandom % 2;
            if (!(b_ie || b_ls || b_id)) b_id = 1'b1;
            t = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : $urandom;
            jump(b_ie, b_ls, b_id, t, $urandom, $urandom);
         end else if ($urandom % 700 == 0) begin
            do_reset();
         end else begin
            tick();
         end
      end
      id_stall = 1'b0;
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
